// File: rtl/ex_mem_latch.sv
// EX/MEM pipeline latch with exception capture and a short IF/ID/EX squash window.
// Overflow or divide-by-zero drops the instruction's side effects and records its EPC.
module ex_mem_latch #(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        Stall,
  input  logic        Flush,
  input  logic        Valid_in,
  input  logic [31:0] ALU_result_in,
  input  logic [31:0] Store_data_in,
  input  logic [31:0] PC_plus_4_in,
  input  logic [4:0]  Write_back_address_in,
  input  logic        Register_write_in,
  input  logic        Memory_read_in,
  input  logic        Memory_write_in,
  input  logic        IO_read_in,
  input  logic        IO_write_in,
  input  logic        Memory_or_IO_in,
  input  logic        Jal_in,
  input  logic        Jalr_in,
  input  logic        Bgezal_in,
  input  logic        Bltzal_in,
  input  logic        Overflow_in,
  input  logic        Divide_zero_in,
  output logic [31:0] ALU_result_ex_mem,
  output logic [31:0] Store_data_ex_mem,
  output logic [31:0] PC_plus_4_ex_mem,
  output logic [4:0]  Write_back_address_ex_mem,
  output logic        Register_write_ex_mem,
  output logic        Memory_read_ex_mem,
  output logic        Memory_write_ex_mem,
  output logic        IO_read_ex_mem,
  output logic        IO_write_ex_mem,
  output logic        Memory_or_IO_ex_mem,
  output logic        Jal_ex_mem,
  output logic        Jalr_ex_mem,
  output logic        Bgezal_ex_mem,
  output logic        Bltzal_ex_mem,
  output logic        Valid_ex_mem,
  output logic [1:0]  Exception_code,
  output logic [31:0] EPC,
  output logic        Flush_request
);

  localparam logic [0:0] StIdle     = 1'b0;
  localparam logic [0:0] StFlushing = 1'b1;

  // Bits 9..5 carry architectural side effects and are dropped on an exception.
  localparam logic [9:0] KeepOnExc = 10'b00000_11111;

  logic [0:0]  state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [9:0]  ctrl_in, ctrl_q, ctrl_d;
  logic        valid_q, valid_d;
  logic [1:0]  code_q, code_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] alu_q, store_q, pc4_q;
  logic [4:0]  wb_q;
  logic        take_exc, bubble;

  assign ctrl_in = {Register_write_in, Memory_read_in, Memory_write_in, IO_read_in, IO_write_in,
                    Memory_or_IO_in, Jal_in, Jalr_in, Bgezal_in, Bltzal_in};

  always_comb begin
    take_exc = (state_q == StIdle) && !Flush && Valid_in && (Overflow_in || Divide_zero_in);
    bubble   = Flush || !Valid_in || (state_q == StFlushing);
    state_d  = state_q;
    cnt_d    = cnt_q;
    code_d   = code_q;
    epc_d    = epc_q;
    valid_d  = !bubble;
    ctrl_d   = ctrl_in;
    if (bubble) begin
      ctrl_d = '0;
    end else if (take_exc) begin
      ctrl_d = ctrl_in & KeepOnExc;
    end
    if (state_q == StFlushing) begin
      cnt_d = cnt_q - 3'd1;
      if (cnt_q <= 3'd1) begin
        state_d = StIdle;
      end
    end else if (take_exc) begin
      state_d = StFlushing;
      cnt_d   = 3'(FLUSH_CYCLES);
      code_d  = Overflow_in ? 2'b01 : 2'b10;
      epc_d   = PC_plus_4_in - 32'd4;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      ctrl_q  <= '0;
      valid_q <= 1'b0;
      code_q  <= '0;
      epc_q   <= '0;
      alu_q   <= '0;
      store_q <= '0;
      pc4_q   <= '0;
      wb_q    <= '0;
    end else if (!Stall) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ctrl_q  <= ctrl_d;
      valid_q <= valid_d;
      code_q  <= code_d;
      epc_q   <= epc_d;
      alu_q   <= ALU_result_in;
      store_q <= Store_data_in;
      pc4_q   <= PC_plus_4_in;
      wb_q    <= Write_back_address_in;
    end
  end

  assign {Register_write_ex_mem, Memory_read_ex_mem, Memory_write_ex_mem, IO_read_ex_mem,
          IO_write_ex_mem, Memory_or_IO_ex_mem, Jal_ex_mem, Jalr_ex_mem, Bgezal_ex_mem,
          Bltzal_ex_mem} = ctrl_q;

  assign ALU_result_ex_mem         = alu_q;
  assign Store_data_ex_mem         = store_q;
  assign PC_plus_4_ex_mem          = pc4_q;
  assign Write_back_address_ex_mem = wb_q;
  assign Valid_ex_mem              = valid_q;
  assign Exception_code            = code_q;
  assign EPC                       = epc_q;
  assign Flush_request             = (state_q == StFlushing);

endmodule

// File: tb/tb_ex_mem_latch.sv
// Bench for ex_mem_latch: directed scenarios then random traffic, all checked against
// a cycle-level model that tracks the squash window as a plain remaining-cycle count.
module tb_ex_mem_latch;

  localparam int unsigned FC = 2;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  logic        stall, flush, valid_in, ov, dz;
  logic [31:0] alu_in, sd_in, pc4_in;
  logic [4:0]  wb_in;
  logic [9:0]  ctrl_in;

  wire [31:0] o_alu, o_sd, o_pc4, o_epc;
  wire [4:0]  o_wb;
  wire [9:0]  o_ctrl;
  wire        o_valid, o_freq;
  wire [1:0]  o_code;

  ex_mem_latch #(.FLUSH_CYCLES(FC)) dut (
    .clock(clock), .reset_n(reset_n), .Stall(stall), .Flush(flush), .Valid_in(valid_in),
    .ALU_result_in(alu_in), .Store_data_in(sd_in), .PC_plus_4_in(pc4_in),
    .Write_back_address_in(wb_in),
    .Register_write_in(ctrl_in[9]), .Memory_read_in(ctrl_in[8]), .Memory_write_in(ctrl_in[7]),
    .IO_read_in(ctrl_in[6]), .IO_write_in(ctrl_in[5]), .Memory_or_IO_in(ctrl_in[4]),
    .Jal_in(ctrl_in[3]), .Jalr_in(ctrl_in[2]), .Bgezal_in(ctrl_in[1]), .Bltzal_in(ctrl_in[0]),
    .Overflow_in(ov), .Divide_zero_in(dz),
    .ALU_result_ex_mem(o_alu), .Store_data_ex_mem(o_sd), .PC_plus_4_ex_mem(o_pc4),
    .Write_back_address_ex_mem(o_wb),
    .Register_write_ex_mem(o_ctrl[9]), .Memory_read_ex_mem(o_ctrl[8]),
    .Memory_write_ex_mem(o_ctrl[7]), .IO_read_ex_mem(o_ctrl[6]), .IO_write_ex_mem(o_ctrl[5]),
    .Memory_or_IO_ex_mem(o_ctrl[4]), .Jal_ex_mem(o_ctrl[3]), .Jalr_ex_mem(o_ctrl[2]),
    .Bgezal_ex_mem(o_ctrl[1]), .Bltzal_ex_mem(o_ctrl[0]),
    .Valid_ex_mem(o_valid), .Exception_code(o_code), .EPC(o_epc), .Flush_request(o_freq)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state
  logic [31:0] m_alu, m_sd, m_pc4, m_epc;
  logic [4:0]  m_wb;
  logic [9:0]  m_ctrl;
  logic        m_valid;
  logic [1:0]  m_code;
  int          m_left;

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_alu = '0; m_sd = '0; m_pc4 = '0; m_epc = '0; m_wb = '0;
    m_ctrl = '0; m_valid = 1'b0; m_code = '0; m_left = 0;
  endtask

  task automatic model_step();
    if (!stall) begin
      m_alu = alu_in; m_sd = sd_in; m_pc4 = pc4_in; m_wb = wb_in;
      if (m_left > 0) begin
        m_ctrl = '0; m_valid = 1'b0; m_left = m_left - 1;
      end else if (flush || !valid_in) begin
        m_ctrl = '0; m_valid = 1'b0;
      end else if (ov || dz) begin
        m_ctrl  = {5'b0, ctrl_in[4:0]};
        m_valid = 1'b1;
        m_code  = ov ? 2'd1 : 2'd2;
        m_epc   = pc4_in - 32'd4;
        m_left  = FC;
      end else begin
        m_ctrl = ctrl_in; m_valid = 1'b1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    check_val({tag, ".data"}, {o_alu, o_sd, o_pc4, o_wb}, {m_alu, m_sd, m_pc4, m_wb});
    check_val({tag, ".ctrl"}, o_ctrl, m_ctrl);
    check_val({tag, ".valid"}, o_valid, m_valid);
    check_val({tag, ".code"}, o_code, m_code);
    check_val({tag, ".epc"}, o_epc, m_epc);
    check_val({tag, ".flushreq"}, o_freq, m_left > 0);
  endtask

  task automatic clear_in();
    stall = 0; flush = 0; valid_in = 1; ov = 0; dz = 0;
    alu_in = '0; sd_in = '0; pc4_in = '0; wb_in = '0; ctrl_in = '0;
  endtask

  // Inputs change at negedge; the model advances on the same posedge the DUT does.
  task automatic cycle(input string tag);
    @(posedge clock);
    if (!reset_n) model_reset();
    else model_step();
    @(negedge clock);
    check_all(tag);
  endtask

  initial begin
    clear_in();
    #1;
    model_reset();
    check_all("reset");
    @(negedge clock);
    reset_n = 1'b1;

    // Pass-through
    alu_in = 32'h1234; ctrl_in = 10'h200; wb_in = 5'd5; pc4_in = 32'h10;
    cycle("pass");
    check_val("pass.alu", o_alu, 32'h1234);
    check_val("pass.regwr", o_ctrl[9], 1'b1);

    // Overflow, then two squashed offers, then normal flow
    clear_in(); ov = 1; ctrl_in = 10'h3FF; pc4_in = 32'h44;
    cycle("ovf");
    check_val("ovf.epc", o_epc, 32'h40);
    check_val("ovf.code", o_code, 2'b01);
    check_val("ovf.regwr", o_ctrl[9], 1'b0);
    clear_in(); ctrl_in = 10'h3FF; alu_in = 32'hA1;
    cycle("ovf.sq1");
    check_val("ovf.sq1.valid", o_valid, 1'b0);
    alu_in = 32'hA2; ov = 1;
    cycle("ovf.sq2");
    clear_in(); alu_in = 32'hA3; ctrl_in = 10'h1C0;
    cycle("ovf.after");
    check_val("ovf.after.freq", o_freq, 1'b0);

    // Both flags, then flush colliding with a new exception
    clear_in(); ov = 1; dz = 1; pc4_in = 32'h100;
    cycle("both");
    clear_in(); cycle("both.w1"); cycle("both.w2");
    ov = 1; flush = 1; pc4_in = 32'h200; ctrl_in = 10'h3FF;
    cycle("flushwin");
    check_val("flushwin.code", o_code, 2'b01);
    check_val("flushwin.epc", o_epc, 32'hFC);

    // Stall for three cycles inside the squash window
    clear_in(); dz = 1; pc4_in = 32'h300;
    cycle("stall.det");
    clear_in(); stall = 1; alu_in = 32'hDEAD;
    for (int i = 0; i < 3; i++) cycle("stall.hold");
    stall = 0;
    cycle("stall.f1"); cycle("stall.f2");
    cycle("stall.end");
    check_val("stall.end.freq", o_freq, 1'b0);

    // Asynchronous reset one cycle into the squash window
    clear_in(); ov = 1; pc4_in = 32'h400;
    cycle("rst.det");
    clear_in();
    cycle("rst.mid");
    reset_n = 1'b0;
    #1;
    model_reset();
    check_all("rst.async");
    @(posedge clock);
    @(negedge clock);
    check_all("rst.held");
    reset_n = 1'b1;
    alu_in = 32'h55; ctrl_in = 10'h200;
    cycle("rst.resume");

    // EPC wrap-around
    clear_in(); dz = 1; pc4_in = 32'h0;
    cycle("wrap");
    check_val("wrap.epc", o_epc, 32'hFFFF_FFFC);
    check_val("wrap.code", o_code, 2'b10);
    clear_in(); cycle("wrap.w1"); cycle("wrap.w2");

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      stall    = ($urandom_range(5) == 0);
      flush    = ($urandom_range(7) == 0);
      valid_in = ($urandom_range(7) != 0);
      ov       = ($urandom_range(9) == 0);
      dz       = ($urandom_range(9) == 0);
      alu_in   = $urandom; sd_in = $urandom; pc4_in = $urandom;
      wb_in    = 5'($urandom); ctrl_in = 10'($urandom);
      cycle("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule

// File: doc/ex_mem_latch.md
EX_MEM_LATCH -- requirements
Module: ex_mem_latch

Interface
REQ-001 Parameter FLUSH_CYCLES, default 2, is the number of cycles Flush_request stays high after an exception is taken (legal range 1..7).
REQ-002 Port clock  in  1  single clock, rising edge.
REQ-003 Port reset_n  in  1  asynchronous, active-low reset.
REQ-004 Port Stall  in  1  hold all latched state.
REQ-005 Port Flush  in  1  insert a bubble (external squash).
REQ-006 Port Valid_in  in  1  the EX stage holds a real instruction.
REQ-007 Ports ALU_result_in, Store_data_in, PC_plus_4_in  in  32 each  EX result, forwarded rt data and PC+4.
REQ-008 Port Write_back_address_in  in  5  destination register.
REQ-009 Ports Register_write_in, Memory_read_in, Memory_write_in, IO_read_in, IO_write_in, Memory_or_IO_in, Jal_in, Jalr_in, Bgezal_in, Bltzal_in  in  1 each  EX control bits.
REQ-010 Ports Overflow_in, Divide_zero_in  in  1 each  EX exception flags.
REQ-011 Outputs are the ten control bits, the data fields and Valid, each with suffix _ex_mem and the same widths as the inputs.
REQ-012 Port Exception_code  out  2  00 none, 01 overflow, 10 divide-by-zero.
REQ-013 Port EPC  out  32  PC of the faulting instruction, which is PC_plus_4_in - 4.
REQ-014 Port Flush_request  out  1  asks IF/ID/EX to squash.

Function
REQ-015 On each rising edge with Stall=0, Flush=0 and the FSM in IDLE, every _ex_mem output SHALL take its input value, with a latency of one cycle.
REQ-016 Stall=1 SHALL hold every register, including the FSM and its counter; Stall has priority over everything except reset.
REQ-017 Flush=1 with Stall=0 SHALL load a bubble: Valid and all control bits become 0, and the data fields latch their inputs.
REQ-018 A bubble SHALL also be loaded whenever Valid_in=0.
REQ-019 Exception detection: Valid_in=1 and (Overflow_in or Divide_zero_in) in IDLE with Stall=0 and Flush=0.
  - The latch SHALL clear Register_write, Memory_read, Memory_write, IO_read and IO_write.
  - It SHALL keep Valid=1, set Exception_code and load EPC.
  - The FSM SHALL move to FLUSHING.
REQ-020 If Overflow_in and Divide_zero_in are both high, Exception_code SHALL be 01 (overflow wins).
REQ-021 FSM states: IDLE and FLUSHING.
  - A 3-bit counter loads FLUSH_CYCLES on entry to FLUSHING and decrements on each non-stalled cycle.
  - The FSM returns to IDLE on the edge where the counter equals 1.
REQ-022 Flush_request SHALL equal (state==FLUSHING), so it is high for exactly FLUSH_CYCLES non-stalled cycles, starting the cycle after detection.
REQ-023 In FLUSHING, incoming instructions SHALL be loaded as bubbles and no new exception SHALL be detected.
REQ-024 Exception_code and EPC SHALL hold their values until the next exception is taken or reset occurs; they are not cleared on return to IDLE.
REQ-025 External Flush and exception detection in the same cycle: Flush wins; no exception is recorded and the state stays IDLE.
REQ-026 The memory/IO one-hot check SHALL be registered only: if more than one of Memory_read_in, Memory_write_in, IO_read_in and IO_write_in is set, all four are latched as given, with no correction.
REQ-027 EPC arithmetic SHALL be 32-bit modulo 2^32, so PC_plus_4_in=0 yields FFFFFFFC.

Reset
REQ-028 reset_n=0 SHALL asynchronously force:
  - all _ex_mem outputs, Exception_code and EPC to 0;
  - Flush_request to 0, the state to IDLE and the counter to 0.
REQ-029 Release of reset_n SHALL take effect on the first rising edge after deassertion; reset asserted during FLUSHING SHALL abort the flush immediately.

Verification
REQ-030 Pass-through: Valid_in=1, ALU_result_in=0x0000_1234, Register_write_in=1, Write_back_address_in=5 -> next cycle ALU_result_ex_mem=0x1234, Register_write_ex_mem=1, Write_back_address_ex_mem=5, Flush_request=0.
REQ-031 Overflow: Valid_in=1, Overflow_in=1, Register_write_in=1, PC_plus_4_in=0x0000_0044 -> Register_write_ex_mem=0, Exception_code=01, EPC=0x40; Flush_request high for exactly 2 cycles; instructions offered in those cycles emerge with Valid_ex_mem=0.
REQ-032 Simultaneous flags: Overflow_in=1 and Divide_zero_in=1 -> Exception_code=01; Flush=1 in the same cycle -> bubble, Exception_code unchanged, Flush_request stays 0.
REQ-033 Stall during FLUSHING: stall for 3 cycles after detection -> Flush_request remains high for 2 non-stalled cycles (5 cycles total), and outputs are frozen while stalled.
REQ-034 Reset mid-flush: assert reset_n=0 asynchronously one cycle after detection -> all outputs are 0 immediately, without waiting for a clock edge; after release, normal pass-through resumes on the next edge.
REQ-035 Wrap-around: divide-by-zero with PC_plus_4_in=0 -> EPC=0xFFFF_FFFC, Exception_code=10.
